uart_cmd_parser: RTL and testbench

//  Consumes the byte stream from uart_rx (dout/dout_vld) and decodes ASCII PC commands

---
 rtl/uart_cmd_parser.sv | 159 +++++++++++++++
 tb/tb_uart_cmd_parser.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// ASCII command decoder fed by uart_rx: 'L'<hex>, 'T'<dec><dec> and '?' frames closed by CR/LF,
// driving the LED pattern, the alarm threshold register and single-cycle event pulses.
module uart_cmd_parser #(
  parameter int unsigned TIMEOUT_CYC = 50_000_000,
  parameter logic [7:0]  DEFAULT_TH  = 8'd30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_vld,
  output logic [3:0] led,
  output logic [7:0] alarm_th,
  output logic       th_upd,
  output logic       query,
  output logic       cmd_err
);

  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {IDLE, ARG1, ARG2, TERM} state_t;
  typedef enum logic [1:0] {CMD_LED, CMD_TH, CMD_QRY} cmd_t;

  state_t        state, state_nxt;
  cmd_t          cmd, cmd_nxt;
  logic [3:0]    arg_hi, arg_hi_nxt;
  logic [3:0]    arg_lo, arg_lo_nxt;
  logic [3:0]    led_nxt;
  logic [7:0]    th_nxt;
  logic          th_upd_nxt, query_nxt, cmd_err_nxt;
  logic [CW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          is_term, is_dig, hex_ok;
  logic [3:0]    hex_val;
  logic [7:0]    th_val;

  assign is_term = (din == 8'h0D) || (din == 8'h0A);
  assign is_dig  = (din >= "0") && (din <= "9");
  assign tmo_hit = (state != IDLE) && (tmo_cnt == CW'(TIMEOUT_CYC - 1));
  assign th_val  = ({4'b0, arg_hi} * 8'd10) + {4'b0, arg_lo};

  // Letters A-F / a-f carry their value in the low nibble offset by 9.
  always_comb begin
    hex_ok  = 1'b1;
    hex_val = din[3:0];
    if (is_dig) begin
      hex_val = din[3:0];
    end else if (((din >= "A") && (din <= "F")) || ((din >= "a") && (din <= "f"))) begin
      hex_val = din[3:0] + 4'd9;
    end else begin
      hex_ok = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (din_vld || (state == IDLE) || tmo_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cmd      <= CMD_LED;
      arg_hi   <= 4'h0;
      arg_lo   <= 4'h0;
      led      <= 4'h0;
      alarm_th <= DEFAULT_TH;
      th_upd   <= 1'b0;
      query    <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cmd      <= cmd_nxt;
      arg_hi   <= arg_hi_nxt;
      arg_lo   <= arg_lo_nxt;
      led      <= led_nxt;
      alarm_th <= th_nxt;
      th_upd   <= th_upd_nxt;
      query    <= query_nxt;
      cmd_err  <= cmd_err_nxt;
    end
  end

  // A rejected byte drops straight back to IDLE without being re-parsed as a new command.
  always_comb begin
    state_nxt   = state;
    cmd_nxt     = cmd;
    arg_hi_nxt  = arg_hi;
    arg_lo_nxt  = arg_lo;
    led_nxt     = led;
    th_nxt      = alarm_th;
    th_upd_nxt  = 1'b0;
    query_nxt   = 1'b0;
    cmd_err_nxt = 1'b0;
    if (din_vld) begin
      unique case (state)
        IDLE: begin
          if ((din == "L") || (din == "l")) begin
            cmd_nxt   = CMD_LED;
            state_nxt = ARG1;
          end else if ((din == "T") || (din == "t")) begin
            cmd_nxt   = CMD_TH;
            state_nxt = ARG1;
          end else if (din == "?") begin
            cmd_nxt   = CMD_QRY;
            state_nxt = TERM;
          end else if (!is_term) begin
            cmd_err_nxt = 1'b1;
          end
        end
        ARG1: begin
          if ((cmd == CMD_LED) && hex_ok) begin
            arg_hi_nxt = hex_val;
            state_nxt  = TERM;
          end else if ((cmd == CMD_TH) && is_dig) begin
            arg_hi_nxt = din[3:0];
            state_nxt  = ARG2;
          end else begin
            cmd_err_nxt = 1'b1;
            state_nxt   = IDLE;
          end
        end
        ARG2: begin
          if (is_dig) begin
            arg_lo_nxt = din[3:0];
            state_nxt  = TERM;
          end else begin
            cmd_err_nxt = 1'b1;
            state_nxt   = IDLE;
          end
        end
        TERM: begin
          state_nxt = IDLE;
          if (is_term) begin
            unique case (cmd)
              CMD_LED: led_nxt = arg_hi;
              CMD_TH: begin
                th_nxt     = th_val;
                th_upd_nxt = 1'b1;
              end
              default: query_nxt = 1'b1;
            endcase
          end else begin
            cmd_err_nxt = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end else if (tmo_hit) begin
      cmd_err_nxt = 1'b1;
      state_nxt   = IDLE;
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: a frame-level string model predicts events into a queue,
// and an independent monitor pops and compares whenever the DUT pulses or changes led.
module tb_uart_cmd_parser;

  localparam int TMO = 100;
  localparam int EV_LED = 0, EV_TH = 1, EV_QRY = 2, EV_ERR = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       din_vld;
  logic [3:0] led;
  logic [7:0] alarm_th;
  logic       th_upd, query, cmd_err;

  uart_cmd_parser #(.TIMEOUT_CYC(TMO), .DEFAULT_TH(8'd30)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .led(led),
    .alarm_th(alarm_th), .th_upd(th_upd), .query(query), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    logic [3:0] led;
    logic [7:0] th;
    int         at;
  } exp_t;

  exp_t       expQ[$];
  logic [7:0] frame[$];
  logic [3:0] mLed;
  logic [7:0] mTh;
  int         lastK;
  int         gapRun;
  int         total = 0;
  int         bad = 0;
  string      hexChars = "0123456789ABCDEFabcdef";

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic void pushEvt(input int kind, input int at);
    exp_t e;
    e = '{kind, mLed, mTh, at};
    expQ.push_back(e);
  endfunction

  function automatic bit isDigit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  function automatic bit isHex(input logic [7:0] b);
    return isDigit(b) || ((b >= "A") && (b <= "F")) || ((b >= "a") && (b <= "f"));
  endfunction

  function automatic int hexVal(input logic [7:0] b);
    if (isDigit(b)) return int'(b) - 48;
    if (b >= "a") return int'(b) - 87;
    return int'(b) - 55;
  endfunction

  // Frame-level reference: collect the frame text, judge it when it ends or stops being a valid prefix.
  function automatic void modelByte(input logic [7:0] b, input int k);
    logic [7:0] c;
    bit         term;
    bit         ok;
    term = (b == 8'h0D) || (b == 8'h0A);
    if (frame.size() == 0) begin
      if (term) return;
      if (b == "L" || b == "l" || b == "T" || b == "t" || b == "?") frame.push_back(b);
      else pushEvt(EV_ERR, k + 1);
      return;
    end
    c = frame[0];
    if (term) begin
      if ((c == "L" || c == "l") && frame.size() == 2) begin
        if (4'(hexVal(frame[1])) != mLed) begin
          mLed = 4'(hexVal(frame[1]));
          pushEvt(EV_LED, k + 1);
        end
      end else if ((c == "T" || c == "t") && frame.size() == 3) begin
        mTh = 8'((int'(frame[1]) - 48) * 10 + (int'(frame[2]) - 48));
        pushEvt(EV_TH, k + 1);
      end else if (c == "?" && frame.size() == 1) begin
        pushEvt(EV_QRY, k + 1);
      end else begin
        pushEvt(EV_ERR, k + 1);
      end
      frame.delete();
      return;
    end
    frame.push_back(b);
    if (c == "L" || c == "l") ok = (frame.size() == 2) && isHex(b);
    else if (c == "T" || c == "t") ok = (frame.size() <= 3) && isDigit(b);
    else ok = 1'b0;
    if (!ok) begin
      pushEvt(EV_ERR, k + 1);
      frame.delete();
    end
  endfunction

  task automatic applyStimulus(input logic [7:0] b);
    din     = b;
    din_vld = 1'b1;
    modelByte(b, cyc);
    lastK  = cyc;
    gapRun = 0;
    @(negedge clk);
    din_vld = 1'b0;
    din     = 8'($urandom);
  endtask

  task automatic idle(input int n);
    if (frame.size() > 0 && gapRun < TMO && gapRun + n >= TMO) begin
      pushEvt(EV_ERR, lastK + 1 + TMO);
      frame.delete();
    end
    gapRun += n;
    repeat (n) @(negedge clk);
  endtask

  task automatic sendStr(input string s);
    for (int i = 0; i < s.len(); i++) applyStimulus(s[i]);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    frame.delete();
    mLed   = 4'h0;
    mTh    = 8'd30;
    gapRun = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (expQ.size() > 0 && w < 300) begin
      idle(1);
      w++;
    end
    checkOutput("queue_drained", expQ.size(), 0);
  endtask

  // Monitor: every DUT-visible event must match the head of the expected queue.
  initial begin : monitor
    logic [3:0] prevLed;
    exp_t       e;
    prevLed = 4'h0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n !== 1'b1) begin
        prevLed = led;
      end else if (th_upd || query || cmd_err || (led !== prevLed)) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_event_cycle", cyc, 32'hFFFF_FFFF);
        end else begin
          e = expQ.pop_front();
          checkOutput("event_cycle", cyc, e.at);
          checkOutput("th_upd", th_upd, e.kind == EV_TH);
          checkOutput("query", query, e.kind == EV_QRY);
          checkOutput("cmd_err", cmd_err, e.kind == EV_ERR);
          checkOutput("led", led, e.led);
          checkOutput("alarm_th", alarm_th, e.th);
        end
        prevLed = led;
      end
    end
  end

  initial begin : stimulus
    int r;
    rst_n   = 1'b0;
    din     = 8'h00;
    din_vld = 1'b0;
    mLed    = 4'h0;
    mTh     = 8'd30;
    gapRun  = 0;
    lastK   = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("reset_led", led, 4'h0);
    checkOutput("reset_alarm_th", alarm_th, 8'd30);
    checkOutput("reset_th_upd", th_upd, 1'b0);
    checkOutput("reset_query", query, 1'b0);
    checkOutput("reset_cmd_err", cmd_err, 1'b0);
    idle(100);
    checkOutput("hold_led", led, 4'h0);
    checkOutput("hold_alarm_th", alarm_th, 8'd30);

    sendStr("T28\r");
    idle(2);
    sendStr("la\n");
    idle(3);
    sendStr("?\r\n");
    idle(3);
    sendStr("T4X");
    idle(2);
    sendStr("L3\r");
    drain();

    sendStr("T1");
    idle(TMO);
    sendStr("5\r");
    drain();
    sendStr("T1");
    idle(TMO - 1);
    sendStr("2\r");
    drain();
    checkOutput("boundary_alarm_th", alarm_th, 8'd12);

    applyStimulus("L");
    doReset();
    sendStr("7\r");
    drain();
    checkOutput("after_reset_led", led, 4'h0);
    checkOutput("after_reset_alarm_th", alarm_th, 8'd30);
    sendStr("T99\n");
    drain();
    checkOutput("b2b_alarm_th", alarm_th, 8'd99);

    for (int f = 0; f < 300; f++) begin
      string s;
      r = $urandom_range(0, 9);
      s = "";
      case (r)
        0, 1, 2: begin
          s = {(($urandom_range(0, 1) == 1) ? "L" : "l"), hexChars.substr($urandom_range(0, 21), 0)};
          s = {s, ($urandom_range(0, 1) == 1) ? "\r\n" : "\n"};
        end
        3, 4: s = {"T", $sformatf("%0d%0d", $urandom_range(0, 9), $urandom_range(0, 9)), "\r"};
        5: s = "?\r";
        6: begin
          s = "x";
          s[0] = 8'($urandom_range(0, 255));
        end
        7: s = {"t", $sformatf("%0d", $urandom_range(0, 9)), "\n"};
        8: begin
          s = {(($urandom_range(0, 1) == 1) ? "L" : "T"), "xx"};
          s[1] = 8'($urandom_range(0, 255));
          s[2] = 8'h0D;
        end
        default: s = "\r\n";
      endcase
      for (int i = 0; i < s.len(); i++) begin
        applyStimulus(s[i]);
        if ($urandom_range(0, 59) == 0) idle(TMO + $urandom_range(0, 3));
        else if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 4));
      end
    end
    idle(TMO + 5);
    drain();
    checkOutput("final_led", led, mLed);
    checkOutput("final_alarm_th", alarm_th, mTh);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
